// File: rtl/inst_fetch.sv
// Instruction fetch front end: drives inst_mem from the PC, tags returned words
// with their PC and queues them for decode; handles redirect/flush and HALT stop.
module inst_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] inst_addr,
    input  logic [15:0] inst,
    input  logic        fetch_en,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_inst,
    output logic [15:0] out_pc,
    output logic        halted
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_WARM,
        S_FETCH,
        S_HALTED
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [15:0]    r_pc;
    logic [15:0]    r_fifo_inst [DEPTH];
    logic [15:0]    r_fifo_pc   [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_pop;
    logic           w_push;
    logic           w_is_halt;

    // A redirect flushes the FIFO, so a pop on that same edge is discarded.
    assign w_pop     = (r_count != '0) & out_ready & ~br_taken;
    assign w_is_halt = (inst[15:10] == HALT_OP);

    assign inst_addr = r_pc;
    assign out_valid = (r_count != '0);
    assign out_inst  = r_fifo_inst[r_rptr];
    assign out_pc    = r_fifo_pc[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WARM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (br_taken) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_WARM:   w_next_state = S_FETCH;
                S_FETCH:  if (w_push && w_is_halt) w_next_state = S_HALTED;
                S_HALTED: w_next_state = S_HALTED;
                default:  w_next_state = S_WARM;
            endcase
        end
    end

    always_comb begin
        w_push = 1'b0;
        halted = 1'b0;
        case (r_state)
            S_FETCH:  w_push = fetch_en & ~br_taken & ((r_count < CW'(DEPTH)) | w_pop);
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (br_taken) begin
            r_pc <= br_target;
        end else if (w_push) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (br_taken) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_inst[r_wptr] <= inst;
                r_fifo_pc[r_wptr]   <= r_pc;
                r_wptr              <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a queue-based predictor builds the expected
// delivery stream, an independent monitor checks every cycle of DUT output.
module tb_inst_fetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'd0;
    localparam logic [5:0]  HALT_OP  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inst_addr;
    logic [15:0] inst = '0;
    logic        fetch_en;
    logic        br_taken;
    logic [15:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        halted;

    logic [15:0] mem [0:65535];

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = warm-up, 1 = fetching, 2 = halted.
    logic [15:0] m_pc   = RESET_PC;
    int          m_mode = 0;
    logic [31:0] exp_q [$];

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_OP(HALT_OP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_addr (inst_addr),
        .inst      (inst),
        .fetch_en  (fetch_en),
        .br_taken  (br_taken),
        .br_target (br_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Memory samples the address on negedge; word is stable at the next posedge.
    always @(negedge clk) inst <= mem[inst_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the expected head and consumes on handshake.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_addr", {16'b0, inst_addr}, {16'b0, RESET_PC});
            chk("rst_out_pc", {16'b0, out_pc}, 32'd0);
            chk("rst_out_inst", {16'b0, out_inst}, 32'd0);
            chk("rst_halted", {31'b0, halted}, 32'd0);
        end else begin
            chk("inst_addr", {16'b0, inst_addr}, {16'b0, m_pc});
            chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
            if (exp_q.size() == 0) begin
                chk("valid_empty", {31'b0, out_valid}, 32'd0);
            end else begin
                chk("valid", {31'b0, out_valid}, 32'd1);
                chk("head_pc", {16'b0, out_pc}, {16'b0, exp_q[0][31:16]});
                chk("head_inst", {16'b0, out_inst}, {16'b0, exp_q[0][15:0]});
                if (out_ready && !br_taken) void'(exp_q.pop_front());
            end
        end
    end

    // Predictor: applies the upcoming edge's effect to the model after the monitor.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
            m_pc   = RESET_PC;
            m_mode = 0;
        end else if (br_taken) begin
            exp_q.delete();
            m_pc   = br_target;
            m_mode = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (fetch_en && exp_q.size() < DEPTH) begin
                exp_q.push_back({m_pc, mem[m_pc]});
                if (mem[m_pc][15:10] == HALT_OP) m_mode = 2;
                m_pc = m_pc + 16'd1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [15:0] saved;
    logic [15:0] w;

    initial begin
        rst_n     = 1'b0;
        fetch_en  = 1'b0;
        out_ready = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:10] == HALT_OP) w[15] = 1'b0;
            mem[i] = w;
        end
        step(3);

        // Streaming from reset
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step(12);

        // Backpressure fills the FIFO, PC stalls at 4
        rst_n = 1'b0;
        step(1);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        step(8);
        chk("full_addr", {16'b0, inst_addr}, 32'd4);
        out_ready = 1'b1;
        step(8);

        // Redirect with three queued
        rst_n = 1'b0;
        step(1);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        step(4);
        br_taken  = 1'b1;
        br_target = 16'd5;
        step(1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        br_taken  = 1'b0;
        out_ready = 1'b1;
        step(6);

        // HALT at address 2, then redirect out of HALTED
        rst_n  = 1'b0;
        saved  = mem[2];
        mem[2] = 16'hFC00;
        step(1);
        rst_n = 1'b1;
        step(10);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_addr", {16'b0, inst_addr}, 32'd3);
        br_taken  = 1'b1;
        br_target = 16'd0;
        step(1);
        chk("unhalt", {31'b0, halted}, 32'd0);
        br_taken = 1'b0;
        step(4);
        rst_n  = 1'b0;
        mem[2] = saved;
        step(1);
        rst_n = 1'b1;
        step(2);

        // PC wrap
        br_taken  = 1'b1;
        br_target = 16'hFFFE;
        step(1);
        br_taken = 1'b0;
        step(6);

        // Async reset with a full FIFO, then redirect coinciding with a pop
        out_ready = 1'b0;
        step(6);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'd0);
        chk("async_addr", {16'b0, inst_addr}, {16'b0, RESET_PC});
        step(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step(4);
        br_taken  = 1'b1;
        br_target = 16'd20;
        step(1);
        br_taken = 1'b0;
        step(5);

        // Randomized traffic
        mem[40] = 16'hFC00;
        mem[60] = 16'hFC05;
        for (int k = 0; k < 600; k++) begin
            fetch_en  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            br_taken  = ($urandom_range(0, 19) == 0);
            br_target = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            rst_n     = ($urandom_range(0, 99) != 0);
            step(1);
        end
        rst_n     = 1'b1;
        br_taken  = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
